// File: rtl/atx_pll_recal_master.sv
// ATX PLL recalibration master.
// Runs one recalibration sequence over an Avalon-MM reconfiguration port:
// request the bus, poll until the arbiter grants it, set the recal bit with a
// read-modify-write, release the bus, then follow the PLL calibration-busy
// handshake.
// Optional feature macro: ATX_RECAL_TIMEOUT_EN adds a per-phase wait timeout
// that forces the error state. Without it the wait phases never time out.
module atx_pll_recal_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned POLL_GAP       = 16
) (
   input  logic        reconfig_clk,
   input  logic        reconfig_reset_n,
   input  logic        recal_start,
   output logic        recal_busy,
   output logic        recal_done,
   output logic        recal_error,
   output logic        reconfig_write,
   output logic        reconfig_read,
   output logic [10:0] reconfig_address,
   output logic [31:0] reconfig_writedata,
   input  logic [31:0] reconfig_readdata,
   input  logic        reconfig_waitrequest,
   input  logic        pll_cal_busy
);

   localparam logic [10:0] AddrArb  = 11'h000;
   localparam logic [10:0] AddrStat = 11'h280;
   localparam logic [10:0] AddrCal  = 11'h100;
   localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   typedef enum logic [3:0] {
      StIdle,
      StReqBus,
      StPollRd,
      StPollGap,
      StRmwRd,
      StRmwWr,
      StRelease,
      StWaitHi,
      StWaitLo,
      StDone,
      StErr
   } state_e;

   state_e            state_q, state_d;
   logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [31:0]       rmw_data_q, rmw_data_d;
   logic              cal_meta_q, cal_sync_q;
   logic              xfer_done;

   // A transfer completes in the first cycle with a command up and no waitrequest.
   assign xfer_done = (reconfig_read | reconfig_write) & ~reconfig_waitrequest;

`ifdef ATX_RECAL_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            tmo_state;
   logic            tmo_hit;

   assign tmo_state = (state_q == StPollRd) || (state_q == StPollGap) ||
                      (state_q == StWaitHi) || (state_q == StWaitLo);
   assign tmo_hit   = (32'(tmo_cnt_q) == TIMEOUT_CYCLES - 32'd1);

   // Timeout counter register.
   always_ff @(posedge reconfig_clk) begin
      if (!reconfig_reset_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   // Two-flop synchronizer for the asynchronous calibration-busy flag.
   always_ff @(posedge reconfig_clk) begin
      if (!reconfig_reset_n) begin
         cal_meta_q <= 1'b0;
         cal_sync_q <= 1'b0;
      end else begin
         cal_meta_q <= pll_cal_busy;
         cal_sync_q <= cal_meta_q;
      end
   end

   // State, poll-gap counter and read-modify-write data registers.
   always_ff @(posedge reconfig_clk) begin
      if (!reconfig_reset_n) begin
         state_q    <= StIdle;
         gap_cnt_q  <= '0;
         rmw_data_q <= '0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         rmw_data_q <= rmw_data_d;
      end
   end

   // Next-state logic; the gap counter only runs inside StPollGap.
   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = '0;
      rmw_data_d = rmw_data_q;
      case (state_q)
         StIdle: begin
            if (recal_start) state_d = StReqBus;
         end
         StReqBus: begin
            if (xfer_done) state_d = StPollRd;
         end
         StPollRd: begin
            if (xfer_done) state_d = reconfig_readdata[2] ? StPollGap : StRmwRd;
         end
         StPollGap: begin
            if (32'(gap_cnt_q) >= POLL_GAP - 32'd1) begin
               state_d = StPollRd;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         StRmwRd: begin
            if (xfer_done) begin
               rmw_data_d = reconfig_readdata;
               state_d    = StRmwWr;
            end
         end
         StRmwWr: begin
            if (xfer_done) state_d = StRelease;
         end
         StRelease: begin
            if (xfer_done) state_d = StWaitHi;
         end
         StWaitHi: begin
            if (cal_sync_q) state_d = StWaitLo;
         end
         StWaitLo: begin
            if (!cal_sync_q) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         StErr: begin
            if (recal_start) state_d = StReqBus;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
`ifdef ATX_RECAL_TIMEOUT_EN
      // Polling and gap share one budget; every other entry restarts the count.
      tmo_cnt_d = '0;
      if (tmo_state) begin
         if (tmo_hit) begin
            state_d = StErr;
         end else if ((state_d == state_q) || (state_d == StPollRd) ||
                      (state_d == StPollGap)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
`endif
   end

   // Bus commands and status decoded from the current state only, so they hold
   // steady under waitrequest and drop at the reset edge.
   always_comb begin
      reconfig_write     = 1'b0;
      reconfig_read      = 1'b0;
      reconfig_address   = '0;
      reconfig_writedata = '0;
      recal_done         = 1'b0;
      recal_busy         = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
`ifdef ATX_RECAL_TIMEOUT_EN
      recal_error        = (state_q == StErr);
`else
      recal_error        = 1'b0;
`endif
      case (state_q)
         StReqBus: begin
            reconfig_write     = 1'b1;
            reconfig_address   = AddrArb;
            reconfig_writedata = 32'h0000_0002;
         end
         StPollRd: begin
            reconfig_read    = 1'b1;
            reconfig_address = AddrStat;
         end
         StRmwRd: begin
            reconfig_read    = 1'b1;
            reconfig_address = AddrCal;
         end
         StRmwWr: begin
            reconfig_write     = 1'b1;
            reconfig_address   = AddrCal;
            reconfig_writedata = rmw_data_q | 32'h0000_0002;
         end
         StRelease: begin
            reconfig_write     = 1'b1;
            reconfig_address   = AddrArb;
            reconfig_writedata = 32'h0000_0001;
         end
         StDone: begin
            recal_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_atx_pll_recal_master.sv
// Scoreboard bench for atx_pll_recal_master: stimulus pushes the expected
// transfer sequence, a negedge monitor pops and compares on each completed
// transfer, done pulse or error entry.
module tb_atx_pll_recal_master;

   localparam int unsigned TMO = 100;
   localparam int unsigned GAP = 16;
   localparam logic [10:0] A_ARB  = 11'h000;
   localparam logic [10:0] A_STAT = 11'h280;
   localparam logic [10:0] A_CAL  = 11'h100;
   localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ERR = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, err, wr, rd, wreq, cal_busy;
   logic [10:0] addr;
   logic [31:0] wdata, rdata;

   always #5 clk = ~clk;

   atx_pll_recal_master #(
      .TIMEOUT_CYCLES(TMO),
      .POLL_GAP      (GAP)
   ) dut (
      .reconfig_clk        (clk),
      .reconfig_reset_n    (rst_n),
      .recal_start         (start),
      .recal_busy          (busy),
      .recal_done          (done),
      .recal_error         (err),
      .reconfig_write      (wr),
      .reconfig_read       (rd),
      .reconfig_address    (addr),
      .reconfig_writedata  (wdata),
      .reconfig_readdata   (rdata),
      .reconfig_waitrequest(wreq),
      .pll_cal_busy        (cal_busy)
   );

   typedef struct {
      int          kind;
      logic [10:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          model_busy = 1'b0;
   int unsigned wait_n = 0, poll_n = 0, cal_len = 20;
   logic [31:0] rmw_val = 32'h0, noise = 32'h0;
   bit          hold_wr100 = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
      end
   endtask

   // Slave: stalls wait_n cycles per transfer, reports busy for poll_n status
   // reads, and pulses calibration-busy after the bus release write.
   logic        cmd;
   int unsigned wcnt = 0, poll_cnt = 0, cal_cnt = 0;
   assign cmd      = rd | wr;
   assign wreq     = cmd && ((wcnt < wait_n) || (hold_wr100 && wr && addr == A_CAL));
   assign rdata    = (addr == A_STAT) ? ((noise & ~32'h4) | {29'd0, poll_cnt < poll_n, 2'd0}) :
                     (addr == A_CAL)  ? rmw_val : 32'h0;
   assign cal_busy = (cal_cnt != 0) && (cal_cnt <= cal_len);

   always @(posedge clk) begin
      if (!cmd || !wreq) wcnt <= 0;
      else               wcnt <= wcnt + 1;
      if (cmd && !wreq && wr && addr == A_ARB && wdata == 32'h2) poll_cnt <= 0;
      else if (cmd && !wreq && rd && addr == A_STAT)             poll_cnt <= poll_cnt + 1;
      if (cmd && !wreq && wr && addr == A_ARB && wdata == 32'h1) cal_cnt <= cal_len + 3;
      else if (cal_cnt != 0)                                     cal_cnt <= cal_cnt - 1;
   end

   // Reference model: one accepted start produces this exact ordered sequence.
   function automatic void push_seq(input int unsigned polls, input logic [31:0] rv,
                                    input bit expect_err);
      exp_q.push_back('{K_WR, A_ARB, 32'h2});
      for (int i = 0; i <= int'(polls); i++) exp_q.push_back('{K_RD, A_STAT, 32'h0});
      exp_q.push_back('{K_RD, A_CAL, 32'h0});
      exp_q.push_back('{K_WR, A_CAL, rv | 32'h2});
      exp_q.push_back('{K_WR, A_ARB, 32'h1});
      exp_q.push_back('{expect_err ? K_ERR : K_DONE, 11'h0, 32'h0});
   endfunction

   // Monitor.
   initial begin : monitor
      exp_t        e;
      int unsigned cyc = 0, last_stat = 0, rel_cyc = 0;
      bit          prev_stat = 1'b0, prev_hold = 1'b0, prev_rst = 1'b0, err_prev = 1'b0;
      logic [44:0] prev_bus = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cmd) chk(!(rd && wr), "rd_wr_exclusive", {30'd0, rd, wr}, 32'h1);
         if (prev_hold && prev_rst)
            chk({rd, wr, addr, wdata} == prev_bus, "hold_stable", {21'd0, addr}, {21'd0, prev_bus[42:32]});
         prev_hold = cmd && wreq;
         prev_bus  = {rd, wr, addr, wdata};
         prev_rst  = rst_n;
         if (cmd && !wreq && rst_n) begin
            chk(exp_q.size() != 0, "xfer_expected", {21'd0, addr}, 32'h0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk(e.kind == (wr ? K_WR : K_RD), "xfer_kind", 32'(wr), 32'(e.kind == K_WR));
               chk(addr == e.addr, "xfer_addr", {21'd0, addr}, {21'd0, e.addr});
               if (wr) chk(wdata == e.data, "xfer_wdata", wdata, e.data);
            end
            if (rd && addr == A_STAT) begin
               if (prev_stat)
                  chk(cyc - last_stat == GAP + 1 + wait_n, "poll_spacing", cyc - last_stat,
                      GAP + 1 + wait_n);
               last_stat = cyc;
               prev_stat = 1'b1;
            end else begin
               prev_stat = 1'b0;
            end
            if (wr && addr == A_ARB && wdata == 32'h1) rel_cyc = cyc;
         end
         if (done) begin
            chk(exp_q.size() != 0, "done_expected", 32'h1, 32'h0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk(e.kind == K_DONE, "done_order", 32'(e.kind), K_DONE);
            end
            chk(!busy, "busy_low_at_done", 32'(busy), 32'h0);
            chk(!err, "error_low_at_done", 32'(err), 32'h0);
            model_busy = 1'b0;
         end
         if (err && !err_prev) begin
            chk(exp_q.size() != 0, "error_expected", 32'h1, 32'h0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk(e.kind == K_ERR, "error_order", 32'(e.kind), K_ERR);
            end
`ifdef ATX_RECAL_TIMEOUT_EN
            chk(cyc - rel_cyc == TMO + 1, "timeout_latency", cyc - rel_cyc, TMO + 1);
`endif
            chk(!busy, "busy_low_at_error", 32'(busy), 32'h0);
            model_busy = 1'b0;
         end
         err_prev = err;
      end
   end

   task automatic pulse_start(input bit expect_err);
      bit accept;
      @(posedge clk); #1;
      start  = 1'b1;
      accept = !model_busy;
      if (accept) begin
         push_seq(poll_n, rmw_val, expect_err);
         model_busy = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (accept) begin
         chk(busy, "busy_after_start", 32'(busy), 32'h1);
         chk(!err, "error_clear_after_start", 32'(err), 32'h0);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 6000 && (model_busy || exp_q.size() != 0); i++) @(negedge clk);
      chk(!model_busy && exp_q.size() == 0, "seq_complete", exp_q.size(), 32'h0);
      exp_q.delete();
      model_busy = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic run_seq(input int unsigned polls, input logic [31:0] rv,
                          input int unsigned wn, input int unsigned cl);
      bit expect_err = 1'b0;
      poll_n  = polls;
      rmw_val = rv;
      wait_n  = wn;
      cal_len = cl;
      noise   = $urandom;
`ifdef ATX_RECAL_TIMEOUT_EN
      expect_err = (cl == 0);
`endif
      pulse_start(expect_err);
      wait_idle();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      // Reset for five cycles and check the idle outputs.
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
      chk(done == 1'b0, "rst_done", 32'(done), 32'h0);
      chk(err == 1'b0, "rst_error", 32'(err), 32'h0);
      chk(wr == 1'b0 && rd == 1'b0, "rst_cmd", {30'd0, rd, wr}, 32'h0);
      chk(addr == 11'h0 && wdata == 32'h0, "rst_bus", wdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Basic sequence, long stall, and three busy polls.
      run_seq(0, 32'h0000_00A4, 0, 20);
      run_seq(0, 32'h0000_00A4, 7, 20);
      run_seq(3, 32'h0000_00A4, 0, 20);

      // Extra starts while busy must be ignored.
      poll_n = 2; rmw_val = 32'h1234_5671; wait_n = 1; cal_len = 15; noise = $urandom;
      pulse_start(1'b0);
      repeat (10) @(posedge clk);
      pulse_start(1'b0);
      repeat (20) @(posedge clk);
      pulse_start(1'b0);
      wait_idle();
      repeat (30) @(negedge clk);

      // Randomized sequences.
      for (int n = 0; n < 8; n++)
         run_seq($urandom_range(0, 3), $urandom, $urandom_range(0, 3), $urandom_range(1, 30));

`ifdef ATX_RECAL_TIMEOUT_EN
      // Calibration never starts: timeout into the error state, then restart.
      run_seq(1, 32'h5A5A_0000, 1, 0);
      repeat (20) @(negedge clk);
      chk(err, "error_sticky", 32'(err), 32'h1);
      run_seq(0, 32'h0000_0F00, 0, 10);
`endif

      // Reset while the read-modify-write is stalled.
      hold_wr100 = 1'b1;
      poll_n = 0; rmw_val = 32'hCAFE_0000; wait_n = 0; cal_len = 10;
      pulse_start(1'b0);
      for (int i = 0; i < 3000 && !(wr && addr == A_CAL); i++) @(negedge clk);
      chk(wr && addr == A_CAL, "reach_rmw_write", {21'd0, addr}, {21'd0, A_CAL});
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      rst_n      = 1'b1;
      start      = 1'b0;
      hold_wr100 = 1'b0;
      exp_q.delete();
      model_busy = 1'b0;
      @(negedge clk);
      chk(wr == 1'b0 && rd == 1'b0, "reset_drops_cmd", {30'd0, rd, wr}, 32'h0);
      chk(addr == 11'h0 && wdata == 32'h0, "reset_bus_zero", wdata, 32'h0);
      chk(!busy && !done && !err, "reset_status_zero", {29'd0, busy, done, err}, 32'h0);
      repeat (40) @(negedge clk);
      chk(!busy, "start_in_reset_ignored", 32'(busy), 32'h0);

      // Recovery after reset.
      run_seq(1, 32'h0000_0004, 2, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/atx_pll_recal_master.md
ATX_PLL_RECAL_MASTER -- requirements
Module: atx_pll_recal_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048576, max cycles allowed per wait phase (poll or cal-busy).
REQ-002 SHALL have parameter POLL_GAP, default 16, idle cycles between successive status polls.
REQ-003 SHALL have port reconfig_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reconfig_reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port recal_start  input  1  single-cycle request to run one recalibration sequence.
REQ-006 SHALL have ports recal_busy / recal_done / recal_error  output  1 each  sequence active / one-cycle success pulse / sticky failure flag.
REQ-007 SHALL have ports reconfig_write, reconfig_read  output  1 each  Avalon-MM master commands.
REQ-008 SHALL have ports reconfig_address  output  11, reconfig_writedata  output  32, reconfig_readdata  input  32, reconfig_waitrequest  input  1.
REQ-009 SHALL have port pll_cal_busy  input  1  PLL calibration-in-progress, asynchronous to reconfig_clk.

Function
REQ-010 SHALL hold read/write, address and writedata stable while reconfig_waitrequest=1; a transfer completes in the first cycle with command high and waitrequest=0.
REQ-011 SHALL never assert reconfig_read and reconfig_write in the same cycle; readdata captured only in the completing cycle of a read.
REQ-012 SHALL pass pll_cal_busy through a 2-flop synchronizer before use.
REQ-013 SHALL implement states IDLE, REQ_BUS, POLL_RD, POLL_GAP, RMW_RD, RMW_WR, RELEASE, WAIT_HI, WAIT_LO, DONE, ERR.
REQ-014 IDLE: recal_start=1 -> REQ_BUS, recal_busy=1 from next cycle; recal_start ignored in all other states.
REQ-015 REQ_BUS: write address 0x000, data 0x0000_0002; on completion -> POLL_RD.
REQ-016 POLL_RD: read 0x280; readdata[2]=0 -> RMW_RD; readdata[2]=1 -> POLL_GAP, wait POLL_GAP cycles, -> POLL_RD.
REQ-017 RMW_RD: read 0x100, latch data; -> RMW_WR.
REQ-018 RMW_WR: write 0x100 with latched data OR 0x0000_0002 (bit1 set, other bits preserved); -> RELEASE.
REQ-019 RELEASE: write 0x000, data 0x0000_0001; -> WAIT_HI.
REQ-020 WAIT_HI: synchronized pll_cal_busy=1 -> WAIT_LO; WAIT_LO: synchronized pll_cal_busy=0 -> DONE.
REQ-021 DONE: recal_done=1 for exactly one cycle, recal_busy=0 same cycle, -> IDLE next cycle.
REQ-022 ERR: recal_error=1, recal_busy=0, commands deasserted; remains until recal_start=1, which clears recal_error and enters REQ_BUS.
REQ-023 SHALL deassert reconfig_read/write in non-bus states; address/writedata don't-care there but driven to 0.

Reset
REQ-024 On reconfig_reset_n=0 at a clock edge: state IDLE, all outputs 0, counters 0, synchronizer flops 0.
REQ-025 Reset mid-transfer SHALL drop command outputs at that edge regardless of waitrequest; no transfer resumes after reset.

Configuration
REQ-026 Macro ATX_RECAL_TIMEOUT_EN defined: a counter cleared on every state entry counts cycles in POLL_RD/POLL_GAP combined and in each of WAIT_HI, WAIT_LO; reaching TIMEOUT_CYCLES -> ERR (command dropped even if waitrequest=1).
REQ-027 Macro ATX_RECAL_TIMEOUT_EN undefined: no timeout counter; those states wait indefinitely; recal_error held 0; ERR unreachable.

Verification
REQ-028 Reset 5 cycles, then recal_start; slave waitrequest=0, 0x280 reads 0x0, 0x100 reads 0x0000_00A4, cal_busy high 20 cycles -> writes 0x000=0x2, 0x100=0x0000_00A6, 0x000=0x1, one recal_done pulse.
REQ-029 Slave holds waitrequest=1 for 7 cycles on each transfer -> address/data/command stable all 7 cycles, each transfer completes once, sequence order unchanged.
REQ-030 0x280 returns bit2=1 for 3 polls then 0 -> exactly 4 reads of 0x280, each separated by POLL_GAP=16 idle cycles.
REQ-031 With ATX_RECAL_TIMEOUT_EN, TIMEOUT_CYCLES=100, pll_cal_busy never rises -> ERR at 100 cycles after WAIT_HI entry, recal_error=1, no recal_done; next recal_start clears error and restarts.
REQ-032 reconfig_reset_n=0 during RMW_WR with waitrequest=1 -> write deasserted at that edge, all outputs 0; recal_start in same cycle as reset ignored.
REQ-033 recal_start pulsed while recal_busy=1 -> no effect, single recal_done at end.
